ac97_link_codec_model: RTL and testbench
========================================

# ac97_link_codec_model

Synthesizable behavioural model of an AC97 codec, sitting on the AC-link opposite the AC97 controller in system-level simulation. It generates `bit_clk` and deserializes 256-bit `sdata_out` frames aligned to `sync`. It exposes the tag and slots 1–4, which carry the command address/data and the left/right PCM samples. It also returns a tag and register-read responses on `sdata_in`, so integration benches can check each PCM sample the controller transmits.

## Interface

Parameters:
- `BIT_CLK_HALF`, default 4: `bit_clk` half-period in `clk` cycles. Must be ≥ 2.
- `READY_FRAMES`, default 2: number of complete frames after `reset_b` deasserts before the codec-ready tag bit sets.

Ports:
- `clk` in 1: the only clock. One clock; reset is synchronous and active-high.
- `rst` in 1: model reset, synchronous, active-high.
- `reset_b` in 1: AC-link cold reset from the controller, active-low.
- `sync` in 1: frame sync from the controller.
- `sdata_out` in 1: serial data, controller → codec.
- `bit_clk` out 1: AC-link bit clock.
- `sdata_in` out 1: serial data, codec → controller.
- `codec_ready` out 1: codec-ready state.
- `slot_0` out 16: last received tag.
- `slot_1` out 20: last valid command address.
- `slot_2` out 20: last valid command data.
- `slot_3` out 20: last valid left PCM slot.
- `slot_4` out 20: last valid right PCM slot.
- `frame_done` out 1: one-`clk` pulse when bit 255 of a frame is sampled.
- `frame_count` out 16: number of completed frames; wraps at 0xFFFF→0.
- `frame_error` out 1: sticky flag, set on a premature `sync` re-assertion.

## Operation

- While `rst`=1 or `reset_b`=0, all outputs are held at 0, `bit_clk` is low, and the bit counter, read-pending flag and ready counter are cleared.
- `bit_clk`:
  - Toggles every `BIT_CLK_HALF` `clk` cycles.
  - The first toggle after reset is a rise.
- Sampling rules:
  - Falling edges of `bit_clk` are sample events.
  - At each sample event, `sync` and `sdata_out` are registered.
- Frame start and bit counting:
  - `sync`=1 at a sample event, with `sync`=0 at the previous sample event, marks bit index 0. This is tag bit 15, sent MSB-first.
  - The index increments at each sample event through 255 and then idles until the next `sync` rise.
- Slot layout:
  - Slot 0 is bits 0–15.
  - Slot n (1..12) is bits 16+20(n−1) through 35+20(n−1), MSB-first.
- Slot latching:
  - `slot_0` updates at bit 15.
  - `slot_1`, `slot_2`, `slot_3` and `slot_4` update at their last bit (35, 55, 75, 95) only if tag bits 14, 13, 12 and 11 respectively are set. Otherwise they hold their previous value.
- Register commands, evaluated at bit 55 when tag bits 14 and 13 are both set:
  - `slot_1[19]`=0 is a write: `regs[slot_1[18:13]] <= slot_2[19:4]`.
  - `slot_1[19]`=1 is a read: sets read-pending for the next frame.
- Codec ready:
  - `codec_ready` sets after `READY_FRAMES` `frame_done` pulses.
  - It stays set until `rst` or `reset_b`=0.
- `sdata_in` output (bit k is the value driven after sample k):
  - Tag bit 15 = `codec_ready`.
  - Tag bits 14 and 13 = read-pending.
  - All other tag bits are 0.
  - If read-pending: slot 1 = `{1'b0, addr[6:0], 12'b0}` and slot 2 = `{data, 4'b0}`. Read-pending clears at the end of that frame.
  - All other slots are 0.
- `sync` rising at a bit index in 1..254 sets `frame_error`, restarts the index at 0, and gives no `frame_done` for the aborted frame.
- `sync` still high after bit 15 is allowed and ignored.

## Timing

- Sample latency: a slot output updates on the `clk` edge of the falling-edge event that samples its last bit. `frame_done` pulses on that same edge for bit 255.
- `sdata_in` changes only on the `clk` edge that raises `bit_clk`, carrying bit k of the current frame after sample event k.
- A register write is visible to a read issued in any later frame. A read response appears in the next frame only.
- Simultaneous write and read in the same frame is impossible, because a single command is decoded per frame.

## Configuration

- `AC97_MODEL_REGFILE_EN` defined: a 64×16 register file, reset to 0, with writes and read responses as above.
- `AC97_MODEL_REGFILE_EN` undefined:
  - No register file.
  - Writes are ignored.
  - Reads still set tag bits 14 and 13 and echo the address in slot 1, with slot 2 = 0.
  - `slot_1` and `slot_2` capture still works.

## Test plan

- Reset: assert `rst` for 10 cycles → all outputs 0 and `bit_clk` low. Release → first `bit_clk` rise after 4 cycles, period 8 `clk`.
- PCM frame: tag 0x9800, slot3 = 50, slot4 = 0xFFFCE → `slot_3`=50, `slot_4`=0xFFFCE, one `frame_done` pulse, `frame_count`=1.
- Invalid slot: next frame with tag 0x8000 and slot3 = 7 → `slot_3` stays 50. After the second frame, `codec_ready`=1 and the following frame's `sdata_in` tag is 0x8000.
- Register round-trip (macro defined): write frame (tag 0xE000, slot1 = 0x02000, slot2 = 0x80000), then read frame (slot1 = 0x82000) → next frame `sdata_in` tag 0xE000, slot1 0x02000, slot2 0x80000.
- Resync: raise `sync` at bit 100 → `frame_error`=1, new frame decodes correctly, no `frame_done` for the aborted frame.
- `reset_b`=0 mid-frame → `bit_clk` low, `codec_ready`=0, counters cleared.

Source files
------------

// File: rtl/ac97_link_codec_model.sv
// ac97_link_codec_model
//
// Behavioural AC97 codec for the far end of an AC-link. It generates
// bit_clk from clk, deserialises the 256-bit sdata_out frames that the
// controller aligns to sync, and exposes the tag and slots 1-4. It also
// drives a tag and register-read responses back on sdata_in.
//
// Optional feature macro: AC97_MODEL_REGFILE_EN
//   defined   - 64x16 register file; write commands update it and read
//               responses return its contents.
//   undefined - no register file; writes are dropped and read responses
//               echo the address with zero data.
//
// Ports
//   clk          in   model clock (the only clock)
//   rst          in   synchronous active-high model reset
//   reset_b      in   AC-link cold reset from the controller, active-low
//   sync         in   frame sync from the controller
//   sdata_out    in   serial data, controller -> codec
//   bit_clk      out  AC-link bit clock, half period BIT_CLK_HALF clk cycles
//   sdata_in     out  serial data, codec -> controller
//   codec_ready  out  set after READY_FRAMES completed frames
//   slot_0       out  last received tag
//   slot_1..4    out  last valid command addr/data, left/right PCM
//   frame_done   out  one-clk pulse when bit 255 is sampled
//   frame_count  out  completed frames, wraps
//   frame_error  out  sticky, premature sync re-assertion seen
//
// Link state
//   state      | meaning
//   LINK_IDLE  | no frame in progress, waiting for a sync rise
//   LINK_FRAME | inside a frame, nxt_idx is the index of the next sample

module ac97_link_codec_model #(
  parameter int BIT_CLK_HALF = 4,
  parameter int READY_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_b,
  input  logic        sync,
  input  logic        sdata_out,
  output logic        bit_clk,
  output logic        sdata_in,
  output logic        codec_ready,
  output logic [15:0] slot_0,
  output logic [19:0] slot_1,
  output logic [19:0] slot_2,
  output logic [19:0] slot_3,
  output logic [19:0] slot_4,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        frame_error
);

  localparam int              HW          = $clog2(BIT_CLK_HALF) + 1;
  localparam logic [HW-1:0]   HALF_RELOAD = HW'(BIT_CLK_HALF - 1);
  localparam logic [15:0]     READY_LOAD  = 16'(READY_FRAMES);

  typedef enum logic {LINK_IDLE, LINK_FRAME} link_state_t;

  logic          in_reset;
  logic [HW-1:0] half_cnt;
  logic          half_tc;
  logic          fall_evt;
  logic          rise_evt;

  link_state_t   link_state;
  logic [7:0]    nxt_idx;
  logic          sync_prev;
  logic          sync_rise;
  logic [18:0]   shreg;
  logic [19:0]   samp_word;
  logic          samp_valid;
  logic [7:0]    samp_idx;

  logic          drv_valid;
  logic [7:0]    drv_idx;
  logic          drv_bit;
  logic [4:0]    s1_off;
  logic [4:0]    s2_off;
  logic [19:0]   resp_s1;
  logic [19:0]   resp_s2;

  logic          rd_req;
  logic [6:0]    rd_req_addr;
  logic [15:0]   rd_req_data;
  logic          rd_pend;
  logic [6:0]    rd_addr;
  logic [15:0]   rd_data;
  logic [15:0]   rd_lookup;

  logic [15:0]   rdy_left;

`ifdef AC97_MODEL_REGFILE_EN
  logic [15:0]   regs [64];
  assign rd_lookup = regs[slot_1[18:13]];
`else
  assign rd_lookup = 16'h0000;
`endif

  assign in_reset  = rst | ~reset_b;
  assign half_tc   = (half_cnt == '0);
  assign fall_evt  = half_tc & bit_clk;
  assign rise_evt  = half_tc & ~bit_clk;
  assign sync_rise = sync & ~sync_prev;
  assign samp_word = {shreg, sdata_out};

  // A sync rise always starts a new frame at index 0, whether idle or not.
  always_comb begin
    samp_valid = 1'b0;
    samp_idx   = nxt_idx;
    if (fall_evt) begin
      if (sync_rise) begin
        samp_valid = 1'b1;
        samp_idx   = 8'd0;
      end else if (link_state == LINK_FRAME) begin
        samp_valid = 1'b1;
      end
    end
  end

  assign resp_s1 = {1'b0, rd_addr, 12'h000};
  assign resp_s2 = {rd_data, 4'h0};
  assign s1_off  = 5'(8'd35 - drv_idx);
  assign s2_off  = 5'(8'd55 - drv_idx);

  // Outgoing bit for the index sampled most recently.
  always_comb begin
    drv_bit = 1'b0;
    if (drv_valid) begin
      if (drv_idx == 8'd0) begin
        drv_bit = codec_ready;
      end else if (drv_idx == 8'd1 || drv_idx == 8'd2) begin
        drv_bit = rd_pend;
      end else if (rd_pend && drv_idx >= 8'd16 && drv_idx <= 8'd35) begin
        drv_bit = resp_s1[s1_off];
      end else if (rd_pend && drv_idx >= 8'd36 && drv_idx <= 8'd55) begin
        drv_bit = resp_s2[s2_off];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      half_cnt    <= HALF_RELOAD;
      bit_clk     <= 1'b0;
      link_state  <= LINK_IDLE;
      nxt_idx     <= 8'd0;
      sync_prev   <= 1'b0;
      shreg       <= '0;
      drv_valid   <= 1'b0;
      drv_idx     <= 8'd0;
      sdata_in    <= 1'b0;
      codec_ready <= 1'b0;
      slot_0      <= '0;
      slot_1      <= '0;
      slot_2      <= '0;
      slot_3      <= '0;
      slot_4      <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      frame_error <= 1'b0;
      rdy_left    <= READY_LOAD;
      rd_req      <= 1'b0;
      rd_req_addr <= '0;
      rd_req_data <= '0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      rd_data     <= '0;
`ifdef AC97_MODEL_REGFILE_EN
      for (int i = 0; i < 64; i++) regs[i] <= '0;
`endif
    end else begin
      frame_done <= 1'b0;

      if (half_tc) begin
        half_cnt <= HALF_RELOAD;
        bit_clk  <= ~bit_clk;
      end else begin
        half_cnt <= half_cnt - HW'(1);
      end

      if (rise_evt) sdata_in <= drv_bit;

      if (rdy_left == 16'd0) codec_ready <= 1'b1;

      if (fall_evt) begin
        sync_prev <= sync;
        shreg     <= samp_word[18:0];
        drv_valid <= samp_valid;
        drv_idx   <= samp_idx;
        // A rise that would land on index 255 simply starts the next frame
        // early; only rises inside 1..254 count as a framing error.
        if (sync_rise && link_state == LINK_FRAME && nxt_idx != 8'd255)
          frame_error <= 1'b1;
      end

      if (samp_valid) begin
        if (samp_idx == 8'd255) begin
          link_state  <= LINK_IDLE;
          nxt_idx     <= 8'd0;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
          // A read decoded in this frame is answered in the next one.
          rd_pend     <= rd_req;
          rd_addr     <= rd_req_addr;
          rd_data     <= rd_req_data;
          rd_req      <= 1'b0;
          if (rdy_left != 16'd0) begin
            rdy_left <= rdy_left - 16'd1;
            if (rdy_left == 16'd1) codec_ready <= 1'b1;
          end
        end else begin
          link_state <= LINK_FRAME;
          nxt_idx    <= samp_idx + 8'd1;
        end

        case (samp_idx)
          8'd15: slot_0 <= samp_word[15:0];
          8'd35: if (slot_0[14]) slot_1 <= samp_word;
          8'd55: begin
            if (slot_0[13]) slot_2 <= samp_word;
            if (slot_0[14] && slot_0[13]) begin
              if (slot_1[19]) begin
                rd_req      <= 1'b1;
                rd_req_addr <= slot_1[18:12];
                rd_req_data <= rd_lookup;
              end
`ifdef AC97_MODEL_REGFILE_EN
              if (!slot_1[19]) regs[slot_1[18:13]] <= samp_word[19:4];
`endif
            end
          end
          8'd75: if (slot_0[12]) slot_3 <= samp_word;
          8'd95: if (slot_0[11]) slot_4 <= samp_word;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac97_link_codec_model.sv
module tb_ac97_link_codec_model;

  logic        clk;
  logic        rst;
  logic        reset_b;
  logic        sync;
  logic        sdata_out;
  logic        bit_clk;
  logic        sdata_in;
  logic        codec_ready;
  logic [15:0] slot_0;
  logic [19:0] slot_1;
  logic [19:0] slot_2;
  logic [19:0] slot_3;
  logic [19:0] slot_4;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        frame_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] s0;
    logic [19:0] s1, s2, s3, s4;
    logic [15:0] cnt;
    logic        err;
    logic        rdy;
  } fd_exp_t;

  typedef struct {
    logic [15:0] tag;
    logic [19:0] s1, s2;
  } rx_exp_t;

  fd_exp_t fd_q[$];
  rx_exp_t rx_q[$];

  ac97_link_codec_model #(.BIT_CLK_HALF(4), .READY_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .reset_b    (reset_b),
    .sync       (sync),
    .sdata_out  (sdata_out),
    .bit_clk    (bit_clk),
    .sdata_in   (sdata_in),
    .codec_ready(codec_ready),
    .slot_0     (slot_0),
    .slot_1     (slot_1),
    .slot_2     (slot_2),
    .slot_3     (slot_3),
    .slot_4     (slot_4),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_fd(input logic [15:0] s0, input logic [19:0] s1, input logic [19:0] s2,
                        input logic [19:0] s3, input logic [19:0] s4, input logic [15:0] cnt,
                        input logic err, input logic rdy);
    fd_exp_t e;
    e.s0 = s0; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.s4 = s4;
    e.cnt = cnt; e.err = err; e.rdy = rdy;
    fd_q.push_back(e);
  endtask

  task automatic exp_rx(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2);
    rx_exp_t e;
    e.tag = tag; e.s1 = s1; e.s2 = s2;
    rx_q.push_back(e);
  endtask

  // Controller side: drive bit j just after the bit_clk rise so the codec
  // samples it on the following fall. Sync is high across the tag.
  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int nbits);
    logic [255:0] fr;
    fr = {tag, s1, s2, s3, s4, 160'h0};
    for (int j = 0; j < nbits; j++) begin
      @(posedge bit_clk);
      #1;
      sync      = (j < 16);
      sdata_out = fr[255-j];
    end
  endtask

  task automatic idle_bits(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge bit_clk);
      #1;
      sync      = 1'b0;
      sdata_out = 1'b0;
    end
  endtask

  // frame_done monitor
  always @(posedge clk) begin
    fd_exp_t e;
    #1;
    if (frame_done === 1'b1) begin
      if (fd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fd_unexpected actual=frame_done required=no_pulse count=%h", frame_count);
      end else begin
        e = fd_q.pop_front();
        check("fd_slot_0", 32'(slot_0), 32'(e.s0));
        check("fd_slot_1", 32'(slot_1), 32'(e.s1));
        check("fd_slot_2", 32'(slot_2), 32'(e.s2));
        check("fd_slot_3", 32'(slot_3), 32'(e.s3));
        check("fd_slot_4", 32'(slot_4), 32'(e.s4));
        check("fd_frame_count", 32'(frame_count), 32'(e.cnt));
        check("fd_frame_error", 32'(frame_error), 32'(e.err));
        check("fd_codec_ready", 32'(codec_ready), 32'(e.rdy));
      end
    end
  end

  // sdata_in receiver: bit k is read at the fall after the fall that
  // sampled bit k; the frame index follows the sync the bench itself drives.
  int          rx_prev_idx = -1;
  int          rx_nxt = 0;
  logic        rx_active = 1'b0;
  logic        rx_prev_sync = 1'b0;
  logic [15:0] rx_tag;
  logic [19:0] rx_s1;
  logic [19:0] rx_s2;

  always @(negedge bit_clk) begin
    int k;
    int cur;
    rx_exp_t e;
    #1;
    if (rst || !reset_b) begin
      rx_prev_idx  = -1;
      rx_nxt       = 0;
      rx_active    = 1'b0;
      rx_prev_sync = 1'b0;
    end else begin
      if (rx_prev_idx >= 0) begin
        k = rx_prev_idx;
        if (k < 16) rx_tag[15-k] = sdata_in;
        else if (k < 36) rx_s1[35-k] = sdata_in;
        else if (k < 56) rx_s2[55-k] = sdata_in;
        if (k == 55) begin
          if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected actual=tag_%h required=no_frame", rx_tag);
          end else begin
            e = rx_q.pop_front();
            check("rx_tag", 32'(rx_tag), 32'(e.tag));
            check("rx_slot_1", 32'(rx_s1), 32'(e.s1));
            check("rx_slot_2", 32'(rx_s2), 32'(e.s2));
          end
        end
      end
      if (sync && !rx_prev_sync) cur = 0;
      else if (rx_active) cur = rx_nxt;
      else cur = -1;
      rx_prev_sync = sync;
      rx_prev_idx  = cur;
      if (cur == 255) rx_active = 1'b0;
      else if (cur >= 0) begin
        rx_active = 1'b1;
        rx_nxt    = cur + 1;
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    logic seen_low;
    logic [19:0] rd_s2;
`ifdef AC97_MODEL_REGFILE_EN
    rd_s2 = 20'h80000;
`else
    rd_s2 = 20'h00000;
`endif
    rst = 1'b1; reset_b = 1'b1; sync = 1'b0; sdata_out = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_bit_clk", 32'(bit_clk), 0);
    check("rst_sdata_in", 32'(sdata_in), 0);
    check("rst_codec_ready", 32'(codec_ready), 0);
    check("rst_slot_0", 32'(slot_0), 0);
    check("rst_slot_1", 32'(slot_1), 0);
    check("rst_slot_2", 32'(slot_2), 0);
    check("rst_slot_3", 32'(slot_3), 0);
    check("rst_slot_4", 32'(slot_4), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    rst = 1'b0;

    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (bit_clk) n = i;
    end
    check("bit_clk_first_rise", n, 4);
    n = 0;
    seen_low = 1'b0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (!bit_clk) seen_low = 1'b1;
      else if (seen_low) n = i;
    end
    check("bit_clk_period", n, 8);

    // F1: PCM frame, slot 1 ignored since tag bit 14 clear
    exp_rx(16'h0000, 20'h0, 20'h0);
    exp_fd(16'h9800, 20'h0, 20'h0, 20'h00032, 20'hFFFCE, 16'd1, 1'b0, 1'b0);
    send_frame(16'h9800, 20'h12345, 20'h0, 20'h00032, 20'hFFFCE, 256);
    // F2: slot 3/4 invalid, hold previous values; ready after this frame
    exp_rx(16'h0000, 20'h0, 20'h0);
    exp_fd(16'h8000, 20'h0, 20'h0, 20'h00032, 20'hFFFCE, 16'd2, 1'b0, 1'b1);
    send_frame(16'h8000, 20'h0, 20'h0, 20'h00007, 20'h00005, 256);
    // F3: register write addr 2 data 0x8000
    exp_rx(16'h8000, 20'h0, 20'h0);
    exp_fd(16'hE000, 20'h02000, 20'h80000, 20'h00032, 20'hFFFCE, 16'd3, 1'b0, 1'b1);
    send_frame(16'hE000, 20'h02000, 20'h80000, 20'h11111, 20'h22222, 256);
    // F4: register read addr 2
    exp_rx(16'h8000, 20'h0, 20'h0);
    exp_fd(16'hE000, 20'h82000, 20'h00000, 20'h00032, 20'hFFFCE, 16'd4, 1'b0, 1'b1);
    send_frame(16'hE000, 20'h82000, 20'h00000, 20'h0, 20'h0, 256);
    // F5: read response on sdata_in
    exp_rx(16'hE000, 20'h02000, rd_s2);
    exp_fd(16'h9800, 20'h82000, 20'h00000, 20'h00100, 20'h00200, 16'd5, 1'b0, 1'b1);
    send_frame(16'h9800, 20'h0, 20'h0, 20'h00100, 20'h00200, 256);
    // F6: aborted at bit 100, no frame_done; response cleared
    exp_rx(16'h8000, 20'h0, 20'h0);
    send_frame(16'h9800, 20'h0, 20'h0, 20'h33333, 20'h44444, 100);
    // F7: resynced frame decodes normally, error flag sticky
    exp_rx(16'h8000, 20'h0, 20'h0);
    exp_fd(16'h9800, 20'h82000, 20'h00000, 20'h00055, 20'h00066, 16'd6, 1'b1, 1'b1);
    send_frame(16'h9800, 20'hABCDE, 20'hABCDE, 20'h00055, 20'h00066, 256);
    // F8: cold reset in the middle of a frame
    send_frame(16'h9800, 20'h0, 20'h0, 20'h00099, 20'h00099, 40);
    @(posedge clk);
    #1;
    reset_b = 1'b0; sync = 1'b0; sdata_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("coldrst_bit_clk", 32'(bit_clk), 0);
    check("coldrst_codec_ready", 32'(codec_ready), 0);
    check("coldrst_frame_count", 32'(frame_count), 0);
    check("coldrst_frame_error", 32'(frame_error), 0);
    check("coldrst_slot_3", 32'(slot_3), 0);
    check("coldrst_sdata_in", 32'(sdata_in), 0);
    reset_b = 1'b1;
    // F9: decoding restarts from clean counters
    exp_rx(16'h0000, 20'h0, 20'h0);
    exp_fd(16'h9800, 20'h0, 20'h0, 20'h00077, 20'h00088, 16'd1, 1'b0, 1'b0);
    send_frame(16'h9800, 20'h12345, 20'h0, 20'h00077, 20'h00088, 256);
    idle_bits(4);
    check("fd_queue_drained", fd_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
